plic_lite: RTL and testbench
============================

Name: plic_lite

Overview:
Parametrised platform-level interrupt controller for the five-stage MCU core, sitting on the core's memory-mapped bus next to the data-memory path. Gathers NUM_SRC external interrupt lines through per-source gateways and arbitrates by programmable priority against a threshold. Raises plic_notif to the core and serves a claim/complete handshake. Successor to the single-bundle, fixed-width PLIC stub; generalised in source count and priority width, with a per-source gateway state and registered arbitration.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..31); source IDs are 1..NUM_SRC and ID 0 means "none".
PRIO_W, 3, priority field width; priority 0 means never interrupt.
ADDR_W, 24, core bus address width.

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
intr_bundle  in  NUM_SRC  interrupt lines, synchronous to clk; bit i-1 is source i
core_wen  in  1  register write strobe
core_ren  in  1  register read strobe
core_addr  in  ADDR_W  byte address; only bits [9:2] are decoded
core_wdata  in  32  write data
core_rdata  out  32  read data, registered, valid the cycle after core_ren
plic_notif  out  1  external interrupt request to the core
claim_id_o  out  5  current winning ID (best_id_q), for debug/trace

Behaviour:
- Reset: all priority, enable, pending and in_service bits are 0; threshold_q = 0; best_id_q = 0; best_prio_q = 0; core_rdata = 0; plic_notif = 0.
- Register map (offsets):
  - 0x000+4*i: priority[i] for i = 1..NUM_SRC; RW; writes truncate to PRIO_W bits; offset 0x000 reads 0.
  - 0x080: pending vector, RO; bit i = source i.
  - 0x100: enable vector, RW; bit 0 and bits above NUM_SRC are forced to 0.
  - 0x180: threshold, RW, PRIO_W bits.
  - 0x184: claim (read) / complete (write).
  - Unmapped offsets read 0; writes to them are ignored.
- Gateway per source:
  - IDLE→PEND when the line is high at a clock edge.
  - PEND→SERV on a claim of that ID.
  - SERV→IDLE on a complete of that ID.
  - While in SERV, line activity is ignored (no new pending).
- Arbitration: combinational max of priority over pending & enable & (priority > 0); ties go to the lowest ID. Result is registered into best_id_q and best_prio_q every cycle.
- plic_notif = (best_prio_q > threshold_q), driven from registers.
- Latency: line rises before edge t → pending at t → best_q at t+1 → plic_notif high during cycle after t+1, i.e. 2 edges.
- Claim read:
  - core_rdata is loaded with best_id_q if best_prio_q > threshold_q, otherwise 0.
  - At the same edge, that source's pending is cleared and in_service is set, and best_id_q/best_prio_q are cleared.
  - A claim in the very next cycle therefore returns 0.
- Complete write: wdata[4:0] = ID. Takes effect only if 1 ≤ ID ≤ NUM_SRC and that source is in SERV; otherwise it is ignored silently.
- Simultaneous core_wen and core_ren: the write is performed, the read is dropped (core_rdata = 0, no claim side effect).
- A claim and a rising line for the same source at the same edge: claim wins and the source enters SERV.
- Disabling a pending source keeps its pending bit; it re-arbitrates when re-enabled.
- Reset asserted mid-operation returns every source to IDLE immediately (asynchronous).

Optional Feature:
- Macro: PLIC_EDGE_TRIG_EN.
- Defined: gateways are edge-triggered. A rising edge of the line (registered previous value) sets pending. One rising edge arriving while in SERV is remembered in a per-source one-deep flag and raises pending right after complete; further edges are lost.
- Undefined: level-triggered as above, with no edge registers or flags.

Decomposition:
- Package plic_pkg holds:
  - Register offsets PLIC_PRIO_BASE, PLIC_PEND_OFF, PLIC_EN_OFF, PLIC_THR_OFF, PLIC_CLAIM_OFF.
  - PLIC_MAX_SRC = 31 and PLIC_ID_W = 5.
  - Gateway state encoding: IDLE, PEND, SERV.
- Sub-module plic_gateway (one per source, generate loop):
  - Inputs: clk, resetn, line, claim, complete.
  - Outputs: pending, in_service.
  - Contains the edge logic under the macro.

Test Plan:
- Reset then read offsets 0x080, 0x100, 0x180, 0x184 → all return 0; plic_notif = 0.
- Set priority[3] = 5, enable bit 3, threshold = 2, then pulse intr_bundle[2] → plic_notif high 2 edges later; claim returns 3; pending[3] clears; plic_notif drops within 1 cycle.
- Set priority[2] = priority[5] = 4, both pending → claim returns 2; complete 2; claim returns 5.
- Set threshold = 4 with best priority 4 → plic_notif stays 0 and claim returns 0; lower threshold to 3 → plic_notif high.
- Hold the line of claimed source 3 high, write complete 7 (not in service) then complete 0 → no state change; write complete 3 → pending reasserts next edge (level mode).
- Under PLIC_EDGE_TRIG_EN, give two rising edges on source 1 while it is in service → after complete exactly one new pending; claim returns 1 once, then 0.

Source files
------------

// File: rtl/plic_pkg.sv
// plic_lite shared constants: register offsets, ID sizing, gateway state encoding.
// No logic, no latency.
// No flow control.
package plic_pkg;
  localparam int PLIC_MAX_SRC = 31;
  localparam int PLIC_ID_W    = 5;

  localparam logic [9:0] PLIC_PRIO_BASE = 10'h000;
  localparam logic [9:0] PLIC_PEND_OFF  = 10'h080;
  localparam logic [9:0] PLIC_EN_OFF    = 10'h100;
  localparam logic [9:0] PLIC_THR_OFF   = 10'h180;
  localparam logic [9:0] PLIC_CLAIM_OFF = 10'h184;

  localparam logic [1:0] GW_IDLE = 2'd0;
  localparam logic [1:0] GW_PEND = 2'd1;
  localparam logic [1:0] GW_SERV = 2'd2;
endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway IDLE/PEND/SERV; edge-triggered with one-deep memory under PLIC_EDGE_TRIG_EN.
// Line to pending: 1 edge.
// No flow control; claim/complete are single-cycle strobes.
module plic_gateway
  import plic_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic line,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic [1:0] state_q, state_d;
  logic       rise;

`ifdef PLIC_EDGE_TRIG_EN
  logic line_q, flag_q, flag_d;

  assign rise = line & ~line_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      line_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      line_q <= line;
      flag_q <= flag_d;
    end
  end
`else
  assign rise = line;
`endif

  always_comb begin
    state_d = state_q;
`ifdef PLIC_EDGE_TRIG_EN
    flag_d  = flag_q;
`endif
    case (state_q)
      GW_IDLE: if (rise) state_d = GW_PEND;
      GW_PEND: if (claim) state_d = GW_SERV;
      GW_SERV: begin
`ifdef PLIC_EDGE_TRIG_EN
        // an edge seen while in service re-raises pending straight after complete
        if (complete) begin
          state_d = (flag_q | rise) ? GW_PEND : GW_IDLE;
          flag_d  = 1'b0;
        end else if (rise) begin
          flag_d = 1'b1;
        end
`else
        if (complete) state_d = GW_IDLE;
`endif
      end
      default: state_d = GW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= GW_IDLE;
    else         state_q <= state_d;
  end

  assign pending    = (state_q == GW_PEND);
  assign in_service = (state_q == GW_SERV);

endmodule

// File: rtl/plic_lite.sv
// Platform-level interrupt controller: gateways, priority/threshold arbitration, claim/complete (PLIC_EDGE_TRIG_EN selects edge gateways).
// Line to plic_notif: 2 edges; core_rdata registered, valid the cycle after core_ren.
// No backpressure; every bus access completes in one cycle, write wins over a simultaneous read.
module plic_lite
  import plic_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ADDR_W  = 24
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_SRC-1:0]   intr_bundle,
  input  logic                 core_wen,
  input  logic                 core_ren,
  input  logic [ADDR_W-1:0]    core_addr,
  input  logic [31:0]          core_wdata,
  output logic [31:0]          core_rdata,
  output logic                 plic_notif,
  output logic [PLIC_ID_W-1:0] claim_id_o
);

  localparam int N = (NUM_SRC > PLIC_MAX_SRC) ? PLIC_MAX_SRC : NUM_SRC;

  logic [9:0]           off, prio_rel;
  logic                 rd_act, claim_rd, claim_ok, comp_wr;
  logic [PLIC_ID_W-1:0] comp_id;
  logic [PRIO_W-1:0]    prio_q [1:N];
  logic [N:1]           en_q, pend, serv;
  logic [PRIO_W-1:0]    thr_q, best_prio_q, best_prio_d;
  logic [PLIC_ID_W-1:0] best_id_q, best_id_d;
  logic [31:0]          rd_val;
  logic                 unused_bits;

  assign off      = {core_addr[9:2], 2'b00};
  assign prio_rel = off - PLIC_PRIO_BASE;
  assign rd_act   = core_ren & ~core_wen;
  assign claim_rd = rd_act && (off == PLIC_CLAIM_OFF);
  assign claim_ok = claim_rd && (best_prio_q > thr_q);
  assign comp_wr  = core_wen && (off == PLIC_CLAIM_OFF);
  assign comp_id  = core_wdata[PLIC_ID_W-1:0];

  for (genvar i = 1; i <= N; i++) begin : g_src
    plic_gateway u_gw (
      .clk        (clk),
      .resetn     (resetn),
      .line       (intr_bundle[i-1]),
      .claim      (claim_ok && (best_id_q == PLIC_ID_W'(i))),
      .complete   (comp_wr && (comp_id == PLIC_ID_W'(i)) && serv[i]),
      .pending    (pend[i]),
      .in_service (serv[i])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i <= N; i++) prio_q[i] <= '0;
      en_q  <= '0;
      thr_q <= '0;
    end else if (core_wen) begin
      for (int i = 1; i <= N; i++)
        if (off < PLIC_PEND_OFF && prio_rel[9:2] == 8'(i))
          prio_q[i] <= core_wdata[PRIO_W-1:0];
      if (off == PLIC_EN_OFF)  en_q  <= core_wdata[N:1];
      if (off == PLIC_THR_OFF) thr_q <= core_wdata[PRIO_W-1:0];
    end
  end

  // strict '>' keeps the lowest ID on equal priority; priority 0 never wins
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    for (int i = 1; i <= N; i++) begin
      if (pend[i] && en_q[i] && prio_q[i] > best_prio_d) begin
        best_prio_d = prio_q[i];
        best_id_d   = PLIC_ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      best_id_q   <= '0;
      best_prio_q <= '0;
    end else if (claim_rd) begin
      best_id_q   <= '0;
      best_prio_q <= '0;
    end else begin
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
    end
  end

  always_comb begin
    rd_val = '0;
    if (off < PLIC_PEND_OFF) begin
      for (int i = 1; i <= N; i++)
        if (prio_rel[9:2] == 8'(i)) rd_val[PRIO_W-1:0] = prio_q[i];
    end else begin
      case (off)
        PLIC_PEND_OFF:  rd_val[N:1] = pend;
        PLIC_EN_OFF:    rd_val[N:1] = en_q;
        PLIC_THR_OFF:   rd_val[PRIO_W-1:0] = thr_q;
        PLIC_CLAIM_OFF: if (best_prio_q > thr_q) rd_val[PLIC_ID_W-1:0] = best_id_q;
        default:        rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) core_rdata <= '0;
    else         core_rdata <= rd_act ? rd_val : '0;
  end

  assign plic_notif  = (best_prio_q > thr_q);
  assign claim_id_o  = best_id_q;
  assign unused_bits = ^{core_addr, core_wdata, intr_bundle};

endmodule

// File: tb/tb_plic_lite.sv
// Randomised and directed bench for plic_lite against a per-source behavioural model.
module tb_plic_lite;
  localparam int NSRC = 8;
  localparam int PW   = 3;
  localparam int AW   = 24;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NSRC-1:0] intr_bundle = '0;
  logic            core_wen = 1'b0;
  logic            core_ren = 1'b0;
  logic [AW-1:0]   core_addr = '0;
  logic [31:0]     core_wdata = '0;
  logic [31:0]     core_rdata;
  logic            plic_notif;
  logic [4:0]      claim_id_o;

  int n_chk = 0;
  int n_err = 0;
  logic [NSRC-1:0] cur_ln = '0;

  always #5 clk = ~clk;

  plic_lite #(.NUM_SRC(NSRC), .PRIO_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .intr_bundle(intr_bundle),
    .core_wen(core_wen), .core_ren(core_ren), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .plic_notif(plic_notif), .claim_id_o(claim_id_o)
  );

  // reference model: per-source pending/in-service flags plus register file
  bit          m_pend [1:NSRC];
  bit          m_serv [1:NSRC];
  bit          m_flag [1:NSRC];
  bit          m_prev [1:NSRC];
  bit          m_en   [1:NSRC];
  int          m_prio [1:NSRC];
  int          m_thr, m_bid, m_bp;
  logic [31:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 1; s <= NSRC; s++) begin
      m_pend[s] = 0; m_serv[s] = 0; m_flag[s] = 0; m_prev[s] = 0;
      m_en[s] = 0; m_prio[s] = 0;
    end
    m_thr = 0; m_bid = 0; m_bp = 0; m_rd = '0;
  endfunction

  function automatic void model_step(input bit wen, input bit ren, input logic [AW-1:0] addr,
                                     input logic [31:0] wd, input logic [NSRC-1:0] ln);
    int  o, nid, np, comp;
    bit  rd, claim_ok, rise;
    o        = int'(addr[9:0]) & 'h3fc;
    rd       = ren && !wen;
    claim_ok = rd && (o == 'h184) && (m_bp > m_thr);
    comp     = (wen && o == 'h184) ? int'(wd[4:0]) : -1;
    m_rd     = '0;
    if (rd) begin
      if (o < 'h80) begin
        if (o / 4 >= 1 && o / 4 <= NSRC) m_rd = 32'(m_prio[o / 4]);
      end else if (o == 'h80) begin
        for (int s = 1; s <= NSRC; s++) m_rd[s] = m_pend[s];
      end else if (o == 'h100) begin
        for (int s = 1; s <= NSRC; s++) m_rd[s] = m_en[s];
      end else if (o == 'h180) begin
        m_rd = 32'(m_thr);
      end else if (o == 'h184) begin
        m_rd = (m_bp > m_thr) ? 32'(m_bid) : 32'd0;
      end
    end
    nid = 0; np = 0;
    for (int s = 1; s <= NSRC; s++)
      if (m_pend[s] && m_en[s] && m_prio[s] > np) begin np = m_prio[s]; nid = s; end
    if (rd && o == 'h184) begin nid = 0; np = 0; end
    for (int s = 1; s <= NSRC; s++) begin
`ifdef PLIC_EDGE_TRIG_EN
      rise = ln[s-1] && !m_prev[s];
`else
      rise = ln[s-1];
`endif
      if (m_serv[s]) begin
        if (comp == s) begin
          m_serv[s] = 0;
`ifdef PLIC_EDGE_TRIG_EN
          m_pend[s] = m_flag[s] || rise;
          m_flag[s] = 0;
`endif
        end else if (rise) begin
          m_flag[s] = 1;
        end
      end else if (m_pend[s]) begin
        if (claim_ok && m_bid == s) begin m_pend[s] = 0; m_serv[s] = 1; end
      end else if (rise) begin
        m_pend[s] = 1;
      end
      m_prev[s] = ln[s-1];
    end
    if (wen) begin
      if (o < 'h80 && o / 4 >= 1 && o / 4 <= NSRC) m_prio[o / 4] = int'(wd[PW-1:0]);
      if (o == 'h100) for (int s = 1; s <= NSRC; s++) m_en[s] = wd[s];
      if (o == 'h180) m_thr = int'(wd[PW-1:0]);
    end
    m_bid = nid; m_bp = np;
  endfunction

  function automatic logic [AW-1:0] mk(input int off);
    logic [AW-1:0] a;
    logic [9:0]    o10;
    a   = AW'($urandom);
    o10 = 10'(off);
    a[9:2] = o10[9:2];
    return a;
  endfunction

  task automatic cycle(input bit wen, input bit ren, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [NSRC-1:0] ln);
    core_wen = wen; core_ren = ren; core_addr = addr; core_wdata = wd; intr_bundle = ln;
    model_step(wen, ren, addr, wd, ln);
    @(negedge clk);
    chk("notif", 32'(plic_notif), 32'(m_bp > m_thr));
    chk("claim_id", 32'(claim_id_o), 32'(m_bid));
    chk("rdata", core_rdata, m_rd);
  endtask

  task automatic idle();            cycle(0, 0, mk($urandom_range(255) * 4), $urandom, cur_ln); endtask
  task automatic wr(input int off, input logic [31:0] d); cycle(1, 0, mk(off), d, cur_ln); endtask
  task automatic rd(input int off); cycle(0, 1, mk(off), $urandom, cur_ln); endtask

  initial begin
    int r, sel;
    logic [31:0] d;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("rst_notif", 32'(plic_notif), 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_id", 32'(claim_id_o), 0);
    rd('h080); chk("rst_pend", core_rdata, 0);
    rd('h100); chk("rst_en", core_rdata, 0);
    rd('h180); chk("rst_thr", core_rdata, 0);
    rd('h184); chk("rst_claim", core_rdata, 0);

    // single source, threshold below priority
    wr('h00c, 5); wr('h100, 32'h08); wr('h180, 2);
    cur_ln = 8'h04; idle(); chk("t1_notif0", 32'(plic_notif), 0);
    cur_ln = 8'h00; idle(); chk("t1_notif1", 32'(plic_notif), 1);
    rd('h184); chk("t1_claim", core_rdata, 3); chk("t1_drop", 32'(plic_notif), 0);
    rd('h080); chk("t1_pend", core_rdata, 0);
    wr('h184, 3);

    // equal priority tie goes to the lower ID
    wr('h008, 4); wr('h014, 4); wr('h100, 32'h24);
    cur_ln = 8'h12; idle(); cur_ln = 8'h00; idle();
    rd('h184); chk("t2_claim2", core_rdata, 2);
    wr('h184, 2); idle();
    rd('h184); chk("t2_claim5", core_rdata, 5);
    wr('h184, 5);

    // threshold equal to best priority masks the request
    wr('h180, 4);
    cur_ln = 8'h02; idle(); cur_ln = 8'h00; idle(); idle();
    chk("t3_notif0", 32'(plic_notif), 0);
    rd('h184); chk("t3_claim0", core_rdata, 0);
    wr('h180, 3); idle(); chk("t3_notif1", 32'(plic_notif), 1);
    rd('h184); chk("t3_claim2", core_rdata, 2);
    wr('h184, 2);

`ifdef PLIC_EDGE_TRIG_EN
    wr('h004, 6); wr('h100, 32'h02);
    cur_ln = 8'h01; idle(); cur_ln = 8'h00; idle();
    rd('h184); chk("e_claim_a", core_rdata, 1);
    cur_ln = 8'h01; idle(); cur_ln = 8'h00; idle();
    cur_ln = 8'h01; idle(); cur_ln = 8'h00; idle();
    wr('h184, 1); idle();
    rd('h184); chk("e_claim1", core_rdata, 1);
    wr('h184, 1); idle(); idle();
    rd('h184); chk("e_claim0", core_rdata, 0);
`else
    // held line, bogus completes ignored, real complete re-pends
    wr('h100, 32'h2c);
    cur_ln = 8'h04; idle(); idle();
    rd('h184); chk("t4_claim", core_rdata, 3);
    wr('h184, 7); wr('h184, 0);
    rd('h080); chk("t4_pend0", core_rdata, 0);
    rd('h184); chk("t4_claim0", core_rdata, 0);
    wr('h184, 3); idle();
    rd('h080); chk("t4_pend1", core_rdata, 32'h08);
    cur_ln = 8'h00;
    rd('h184); chk("t4_claim3", core_rdata, 3);
    wr('h184, 3);
`endif

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2 resetn = 1'b0;
        #1;
        chk("arst_notif", 32'(plic_notif), 0);
        chk("arst_rdata", core_rdata, 0);
        chk("arst_id", 32'(claim_id_o), 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
      end
      if ($urandom_range(3) == 0) cur_ln = NSRC'($urandom);
      r = $urandom_range(99);
      if (r < 30) idle();
      else if (r < 50) rd('h184);
      else if (r < 65) begin
        d = ($urandom & 32'hffff_ffe0) | 32'($urandom_range(0, 10));
        wr('h184, d);
      end else if (r < 85) begin
        sel = $urandom_range(11);
        if (sel < 8)        wr(4 * (sel + 1), $urandom);
        else if (sel == 8)  wr('h100, $urandom);
        else if (sel == 9)  wr('h180, $urandom_range(0, 3));
        else if (sel == 10) wr('h000, $urandom);
        else                wr(4 * $urandom_range(98, 255), $urandom);
      end else if (r < 95) rd(4 * $urandom_range(255));
      else cycle(1, 1, mk(($urandom_range(1) == 0) ? 'h184 : 'h180), $urandom_range(0, 9), cur_ln);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
